// File: rtl/memory_io_pkg.sv
// Request/response word formats shared by the core data port, the data memory and the MMIO bridge.
package memory_io_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  do_read;
        logic [3:0]  do_write;
    } memory_io_req;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
    } memory_io_rsp;

endpackage

// File: rtl/mmio_console_bridge.sv
// Data-port bridge owning the MMIO window: memory traffic passes through combinationally, MMIO reads answer next cycle.
// Console bytes queue in a FIFO drained by char_valid/char_ready; a push into a full FIFO is dropped unless a pop frees a slot.
module mmio_console_bridge
    import memory_io_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] TX_ADDR     = 32'h0002_FFF8,
    parameter logic [31:0] HALT_ADDR   = 32'h0002_FFFC,
    parameter logic [31:0] STATUS_ADDR = 32'h0002_FFF4
) (
    input  logic         clk,
    input  logic         reset,
    input  memory_io_req core_req,
    output memory_io_rsp core_rsp,
    output memory_io_req mem_req,
    input  memory_io_rsp mem_rsp,
    output logic         char_valid,
    output logic [7:0]   char_data,
    input  logic         char_ready,
    output logic         halt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } halt_state_t;

    logic          hit_tx;
    logic          hit_halt;
    logic          hit_status;
    logic          mmio_hit;
    logic          tx_wr;
    logic          halt_wr;
    logic          mmio_rd;

    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          overflow;
    logic          drained;

    halt_state_t   state;
    halt_state_t   state_nxt;
    logic          halt_pending;
    logic          halted;

    logic [7:0]    count8;
    logic [31:0]   status_word;
    memory_io_rsp  mmio_rsp;

    // Address decode: exact word match only, so nearby addresses still reach memory.
    assign hit_tx     = core_req.valid && (core_req.addr == TX_ADDR);
    assign hit_halt   = core_req.valid && (core_req.addr == HALT_ADDR);
    assign hit_status = core_req.valid && (core_req.addr == STATUS_ADDR);
    assign mmio_hit   = hit_tx || hit_halt || hit_status;
    assign tx_wr      = hit_tx && (core_req.do_write != 4'h0);
    assign halt_wr    = hit_halt && (core_req.do_write != 4'h0);
    assign mmio_rd    = mmio_hit && (core_req.do_read != 4'h0);

    always_comb begin
        mem_req       = core_req;
        mem_req.valid = core_req.valid && !mmio_hit;
    end

    // Console FIFO; pointers carry a wrap bit so full and empty are distinguishable.
    assign count       = wptr - rptr;
    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign char_valid  = !empty;
    assign pop         = char_valid && char_ready;
    assign push        = tx_wr && (!full || pop);
    assign count_after = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign char_data   = empty ? 8'h00 : fifo_mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing is visible until a push moves wptr.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr[AW-1:0]] <= core_req.data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (tx_wr && !push) begin
            overflow <= 1'b1;
        end
    end

    // Drained looks at the post-edge occupancy so halt rises right after the final pop.
    assign drained = !push && (count_after == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        halt_pending = 1'b0;
        halted       = 1'b0;
        case (state)
            RUN: begin
                if (halt_wr) begin
                    state_nxt = drained ? HALTED : DRAIN;
                end
            end
            DRAIN: begin
                halt_pending = 1'b1;
                if (drained) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                halt_pending = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign halt = halted;

    assign count8      = 8'(count);
    assign status_word = {15'b0, overflow, 6'b0, halt_pending, halted, count8};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmio_rsp <= '0;
        end else begin
            mmio_rsp.valid <= mmio_rd;
            if (mmio_rd) begin
                mmio_rsp.addr <= core_req.addr;
                mmio_rsp.data <= hit_status ? status_word : 32'h0;
            end
        end
    end

    // Each request routes to exactly one target, so the two responses never overlap.
    assign core_rsp = mmio_rsp.valid ? mmio_rsp : mem_rsp;

endmodule

// File: tb/tb_mmio_console_bridge.sv
// Randomized and directed bench for mmio_console_bridge against a queue-based reference model.
module tb_mmio_console_bridge;
    import memory_io_pkg::*;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] TX_A   = 32'h0002_FFF8;
    localparam logic [31:0] HALT_A = 32'h0002_FFFC;
    localparam logic [31:0] STAT_A = 32'h0002_FFF4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    memory_io_req core_req;
    memory_io_rsp core_rsp;
    memory_io_req mem_req;
    memory_io_rsp mem_rsp;
    logic         char_valid;
    logic [7:0]   char_data;
    logic         char_ready;
    logic         halt;

    always #5 clk = ~clk;

    mmio_console_bridge #(
        .FIFO_DEPTH (DEPTH),
        .TX_ADDR    (TX_A),
        .HALT_ADDR  (HALT_A),
        .STATUS_ADDR(STAT_A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_req  (core_req),
        .core_rsp  (core_rsp),
        .mem_req   (mem_req),
        .mem_rsp   (mem_rsp),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .halt      (halt)
    );

    // Data memory stand-in with a one-cycle read response.
    logic [31:0] stub_ram [256];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rsp <= '0;
        end else begin
            mem_rsp.valid <= mem_req.valid && (mem_req.do_read != 4'h0);
            mem_rsp.addr  <= mem_req.addr;
            mem_rsp.data  <= stub_ram[mem_req.addr[9:2]];
            if (mem_req.valid && (mem_req.do_write != 4'h0)) begin
                stub_ram[mem_req.addr[9:2]] <= mem_req.data;
            end
        end
    end

    // Reference model state.
    logic [7:0]  q[$];
    bit          ovf;
    bit          hp;
    bit          hd;
    bit          ev;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [31:0] exp_ram [logic [31:0]];

    int checks = 0;
    int errors = 0;

    logic [31:0] maddr [5] = '{32'h0000_0100, 32'h0000_0104, 32'h0002_FFF0, 32'h0003_FFF8, 32'h0002_FFEC};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_mmio(input logic [31:0] a);
        return (a == TX_A) || (a == HALT_A) || (a == STAT_A);
    endfunction

    task automatic model_reset();
        q.delete();
        ovf = 0;
        hp  = 0;
        hd  = 0;
        ev  = 0;
    endtask

    task automatic model_step();
        int          sz;
        bit          pop;
        bit          push;
        bit          rd;
        bit          wr;
        bit          nev;
        logic [31:0] nea;
        logic [31:0] ned;
        sz   = q.size();
        pop  = (sz > 0) && char_ready;
        push = 0;
        nev  = 0;
        nea  = '0;
        ned  = '0;
        rd   = core_req.do_read != 4'h0;
        wr   = core_req.do_write != 4'h0;
        if (core_req.valid) begin
            if (core_req.addr == STAT_A) begin
                if (rd) begin
                    nev = 1;
                    nea = core_req.addr;
                    ned = (32'(ovf) << 16) + (32'(hp) << 9) + (32'(hd) << 8) + 32'(sz);
                end
            end else if (core_req.addr == TX_A) begin
                if (rd) begin
                    nev = 1;
                    nea = core_req.addr;
                end
                if (wr) begin
                    if (sz == DEPTH && !pop) ovf = 1;
                    else push = 1;
                end
            end else if (core_req.addr == HALT_A) begin
                if (rd) begin
                    nev = 1;
                    nea = core_req.addr;
                end
                if (wr) hp = 1;
            end else begin
                if (rd) begin
                    nev = 1;
                    nea = core_req.addr;
                    ned = exp_ram.exists(core_req.addr) ? exp_ram[core_req.addr] : 32'h0;
                end
                if (wr) exp_ram[core_req.addr] = core_req.data;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(core_req.data[7:0]);
        if (hp && !hd && !push && q.size() == 0) hd = 1;
        ev = nev;
        ea = nea;
        ed = ned;
    endtask

    task automatic drv(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] rd, input logic [3:0] wr);
        core_req.valid    = v;
        core_req.addr     = a;
        core_req.data     = d;
        core_req.do_read  = rd;
        core_req.do_write = wr;
    endtask

    task automatic cycle();
        bit mmio;
        #1;
        mmio = is_mmio(core_req.addr);
        chk("char_valid", char_valid, q.size() != 0);
        chk("char_data", char_data, (q.size() != 0) ? q[0] : 8'h00);
        chk("halt", halt, hd);
        chk("mem_valid", mem_req.valid, core_req.valid && !mmio);
        if (core_req.valid && !mmio) begin
            chk("mem_addr", mem_req.addr, core_req.addr);
            chk("mem_data", mem_req.data, core_req.data);
            chk("mem_cmd", {mem_req.do_read, mem_req.do_write}, {core_req.do_read, core_req.do_write});
        end
        chk("rsp_valid", core_rsp.valid, ev);
        if (ev) begin
            chk("rsp_addr", core_rsp.addr, ea);
            chk("rsp_data", core_rsp.data, ed);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr_op(input logic [31:0] a, input logic [31:0] d);
        drv(1, a, d, 4'h0, 4'hF);
        cycle();
    endtask

    task automatic rd_op(input logic [31:0] a);
        drv(1, a, 32'h0, 4'hF, 4'h0);
        cycle();
    endtask

    task automatic idle();
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        cycle();
    endtask

    task automatic apply_reset();
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #2 reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int got;
        int lastpop;
        int rise;
        int op;
        core_req   = '0;
        char_ready = 1'b0;
        model_reset();

        // Reset values
        #3;
        chk("rst_halt", halt, 1'b0);
        chk("rst_char_valid", char_valid, 1'b0);
        chk("rst_char_data", char_data, 8'h00);
        chk("rst_rsp_valid", core_rsp.valid, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Pass-through
        for (int i = 0; i < 5; i++) wr_op(maddr[i], 32'h1000_0000 + i);
        wr_op(32'h0000_0100, 32'hDEAD_BEEF);
        rd_op(32'h0000_0100);
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("pt_valid", core_rsp.valid, 1'b1);
        chk("pt_data", core_rsp.data, 32'hDEAD_BEEF);
        cycle();
        rd_op(STAT_A);
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("pt_count", core_rsp.data, 32'h0);
        cycle();

        // Console stream
        char_ready = 1'b1;
        wr_op(TX_A, 32'h48);
        drv(1, TX_A, 32'h69, 4'h0, 4'hF);
        #1;
        chk("stream_h", char_data, 8'h48);
        chk("stream_mem_valid", mem_req.valid, 1'b0);
        cycle();
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("stream_i", char_data, 8'h69);
        cycle();
        idle();

        // Overflow
        char_ready = 1'b0;
        for (int i = 0; i < 17; i++) wr_op(TX_A, 32'h41 + i);
        rd_op(STAT_A);
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("ovf_status", core_rsp.data, 32'h0001_0010);
        cycle();
        char_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 24; i++) begin
            drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
            #1;
            if (char_valid) begin
                chk("ovf_char", char_data, 32'h41 + got);
                got++;
            end
            cycle();
        end
        chk("ovf_drained", got, 16);

        // Full with simultaneous pop
        apply_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 16; i++) wr_op(TX_A, 32'h60 + i);
        char_ready = 1'b1;
        wr_op(TX_A, 32'h5A);
        char_ready = 1'b0;
        rd_op(STAT_A);
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("fullpop_status", core_rsp.data, 32'h0000_0010);
        cycle();
        char_ready = 1'b1;
        for (int i = 0; i < 20; i++) idle();

        // Halt after drain
        apply_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr_op(TX_A, 32'h31 + i);
        wr_op(HALT_A, 32'h1);
        rd_op(STAT_A);
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("halt_status", core_rsp.data, 32'h0000_0203);
        chk("halt_early", halt, 1'b0);
        char_ready = 1'b1;
        lastpop = -1;
        rise    = -1;
        for (int i = 0; i < 10; i++) begin
            drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
            #1;
            if (char_valid && char_ready) lastpop = i;
            if (halt && rise < 0) rise = i;
            cycle();
        end
        chk("halt_delay", rise - lastpop, 1);
        chk("halt_sticky", halt, 1'b1);

        // TX then HALT back to back, then HALT on an empty FIFO
        apply_reset();
        char_ready = 1'b1;
        wr_op(TX_A, 32'h5A);
        drv(1, HALT_A, 32'h0, 4'h0, 4'h1);
        #1;
        chk("order_char_first", {char_valid, halt}, 2'b10);
        cycle();
        for (int i = 0; i < 3; i++) idle();
        apply_reset();
        wr_op(HALT_A, 32'h0);
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("halt_empty", halt, 1'b1);
        cycle();

        // Async reset mid-drain
        apply_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr_op(TX_A, 32'h70 + i);
        wr_op(HALT_A, 32'h1);
        char_ready = 1'b1;
        idle();
        #2 reset = 1'b0;
        #1;
        chk("areset_char_valid", char_valid, 1'b0);
        chk("areset_halt", halt, 1'b0);
        chk("areset_char_data", char_data, 8'h00);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        rd_op(STAT_A);
        drv(0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;
        chk("areset_status", core_rsp.data, 32'h0);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            char_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
                continue;
            end
            op = $urandom_range(0, 99);
            if (op < 20) begin
                drv(0, $urandom, $urandom, 4'h0, 4'h0);
            end else if (op < 35) begin
                drv(1, maddr[$urandom_range(0, 4)], $urandom, 4'h0, 4'hF);
            end else if (op < 50) begin
                drv(1, maddr[$urandom_range(0, 4)], 32'h0, 4'hF, 4'h0);
            end else if (op < 70) begin
                drv(1, TX_A, $urandom, 4'h0, ($urandom_range(0, 9) == 0) ? 4'h0 : 4'(($urandom_range(1, 15))));
            end else if (op < 80) begin
                drv(1, STAT_A, 32'h0, 4'(($urandom_range(1, 15))), 4'h0);
            end else if (op < 85) begin
                drv(1, ($urandom_range(0, 1) != 0) ? TX_A : HALT_A, 32'h0, 4'hF, 4'h0);
            end else if (op < 88) begin
                drv(1, STAT_A, $urandom, 4'h0, 4'hF);
            end else if (op < 89) begin
                drv(1, HALT_A, $urandom, 4'h0, 4'h1);
            end else begin
                drv(1, ($urandom_range(0, 1) != 0) ? TX_A : HALT_A, $urandom, 4'h0, 4'h0);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
